fw_local_intc_wb_dispatch: RTL and testbench
============================================

Name: fw_local_intc_wb_dispatch

Overview:
Wishbone initiator that services the local interrupt controller from the bus side. On `irq` it reads the controller's pending register and selects the lowest-index pending source. It hands that source to a consumer over a valid/ready port, then writes a one-hot W1C acknowledge back to the controller. It sits between the fw_local_intc Wishbone target and a hart-side or sequencer-side interrupt consumer.

Parameters:
N_SRCS, 1, number of interrupt sources (1..32); bit i of the pending word = source i.
ADR_W, 32, Wishbone address width.
PEND_ADDR, 32'h0, byte address of the pending register (read).
ACK_ADDR, 32'h4, byte address of the acknowledge register (write-1-to-clear).
TIMEOUT, 16, cycles cyc may stay asserted without ack/err before abort (>=2).

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
irq  in  1  level interrupt from the controller.
m_adr  out  ADR_W  Wishbone address.
m_dat_w  out  32  write data.
m_dat_r  in  32  read data.
m_cyc  out  1  cycle.
m_stb  out  1  strobe.
m_we  out  1  write enable.
m_sel  out  4  byte selects; always 4'hF.
m_ack  in  1  target acknowledge.
m_err  in  1  target error.
vec_valid  out  1  dispatched source valid.
vec_ready  in  1  consumer accepts.
vec_id  out  ID_W  selected source index; ID_W = max(1, clog2(N_SRCS)).
vec_pend  out  N_SRCS  full pending snapshot from the read.
spurious  out  1  one-cycle pulse: read returned no pending bits.
bus_fault  out  1  one-cycle pulse: timeout or m_err.

Behaviour:
- Reset state (reset low, asynchronous): state=IDLE; m_cyc=m_stb=m_we=0; m_adr=0; m_dat_w=0; vec_valid=0; vec_id=0; vec_pend=0; spurious=bus_fault=0; timeout counter=0.
  - Reset asserted mid-cycle drops m_cyc/m_stb immediately; no completion is owed.
- All outputs are registered.
- States: IDLE -> RD -> PRESENT -> WR -> HOLD -> IDLE.
- IDLE: when `irq`=1 is sampled, go to RD on the next edge. Set m_cyc=m_stb=1, m_we=0, m_adr=PEND_ADDR.
- RD: hold cyc/stb/adr stable until m_ack or m_err is sampled.
  - m_ack: capture p = m_dat_r[N_SRCS-1:0] and drop cyc/stb on the next edge.
    - p==0: pulse spurious, go to HOLD.
    - Otherwise: vec_pend=p, vec_id=lowest set index of p, vec_valid=1, go to PRESENT.
  - Bits above N_SRCS are ignored.
- PRESENT: vec_valid, vec_id and vec_pend stay stable until vec_ready=1 is sampled.
  - On that edge: vec_valid=0, go to WR with m_cyc=m_stb=m_we=1, m_adr=ACK_ADDR, m_dat_w=(1<<vec_id).
- WR: on m_ack, drop cyc/stb/we and go to HOLD.
- HOLD: wait 2 cycles so the controller's registered irq can deassert, then go to IDLE. An irq still high at IDLE re-enters RD; remaining sources are served this way, one per pass.
- Timeout: the counter resets on entry to RD/WR and increments each cycle cyc is high.
  - On reaching TIMEOUT with no ack/err, or on m_err in RD/WR: drop cyc/stb/we, pulse bus_fault, go to HOLD. No vec_valid is issued for that pass.
  - m_ack and m_err in the same cycle: treated as err.
- Handshake latency against a one-wait-state target: irq sampled at edge 0 -> cyc at 1 -> ack at 2 -> vec_valid at 3.
- Wishbone classic rules:
  - Never assert stb without cyc.
  - cyc/stb deassert the cycle after ack is sampled.
  - ack is ignored outside RD/WR.
- vec_ready while vec_valid=0 is ignored.

Decomposition:
- Package fw_local_intc_pkg: state enum (IDLE, RD, PRESENT, WR, HOLD), HOLD_CYCLES=2, default register offsets.
- Sub-module fw_local_intc_prio_enc: combinational lowest-index priority encoder, N_SRCS in -> ID_W index plus any-set flag.
- The dispatch block holds the FSM, the timeout counter and the output registers.

Test Plan:
- Single source: N_SRCS=4, pend=4'b0100, vec_ready tied 1 -> one read at 0x0, vec_id=2, vec_pend=4'b0100, one write of 32'h4 to 0x4, then IDLE.
- Multiple pending: pend=4'b1010 -> first vec_id=1 and ack write 32'h2. Model clears bit 1 and irq stays high -> second pass vec_id=3, write 32'h8.
- Backpressure: hold vec_ready=0 for 10 cycles -> vec_valid/vec_id stable and m_cyc=0 throughout; the write starts the cycle after ready.
- Spurious: read returns 0 -> spurious pulses exactly once, vec_valid never asserts, no write cycle.
- Fault: target never acks, TIMEOUT=16 -> cyc drops after 16 cycles and bus_fault pulses once. Separate run with m_err on the read -> bus_fault pulses, no vec_valid.
- Reset mid-read: pull reset low while m_cyc=1 -> m_cyc/m_stb low in the same cycle. After release the block is in IDLE and restarts on irq.

Source files
------------

// File: rtl/fw_local_intc_pkg.sv
// rtl/fw_local_intc_pkg.sv - shared types and constants for the local interrupt controller dispatch path
package fw_local_intc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_PRESENT,
        ST_WR,
        ST_HOLD
    } state_e;

    // Gives the controller's registered irq time to fall after an acknowledge.
    localparam int HOLD_CYCLES = 2;

    localparam logic [31:0] DEF_PEND_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_ACK_ADDR  = 32'h0000_0004;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fw_local_intc_prio_enc.sv
// rtl/fw_local_intc_prio_enc.sv - lowest-index priority encoder over the pending word
module fw_local_intc_prio_enc #(
    parameter int N_SRCS = 1,
    parameter int ID_W   = 1
) (
    input  logic [N_SRCS-1:0] req_i,
    output logic [ID_W-1:0]   id_o,
    output logic              any_o
);

    // Scanning downwards lets the lowest set index be the last one written.
    always_comb begin
        id_o  = '0;
        any_o = 1'b0;
        for (int i = N_SRCS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o  = ID_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fw_local_intc_wb_dispatch.sv
// rtl/fw_local_intc_wb_dispatch.sv - Wishbone initiator that reads, dispatches and acknowledges local interrupts
module fw_local_intc_wb_dispatch
    import fw_local_intc_pkg::*;
#(
    parameter int               N_SRCS    = 1,
    parameter int               ADR_W     = 32,
    parameter logic [ADR_W-1:0] PEND_ADDR = ADR_W'(DEF_PEND_ADDR),
    parameter logic [ADR_W-1:0] ACK_ADDR  = ADR_W'(DEF_ACK_ADDR),
    parameter int               TIMEOUT   = 16,
    localparam int              ID_W      = id_width(N_SRCS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              irq,
    output logic [ADR_W-1:0]  m_adr,
    output logic [31:0]       m_dat_w,
    input  logic [31:0]       m_dat_r,
    output logic              m_cyc,
    output logic              m_stb,
    output logic              m_we,
    output logic [3:0]        m_sel,
    input  logic              m_ack,
    input  logic              m_err,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [ID_W-1:0]   vec_id,
    output logic [N_SRCS-1:0] vec_pend,
    output logic              spurious,
    output logic              bus_fault
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_e              state_q;
    logic [TW-1:0]       tmo_q;
    logic [HW-1:0]       hold_q;
    logic [ADR_W-1:0]    m_adr_q;
    logic [31:0]         m_dat_w_q;
    logic                m_cyc_q;
    logic                m_stb_q;
    logic                m_we_q;
    logic                vec_valid_q;
    logic [ID_W-1:0]     vec_id_q;
    logic [N_SRCS-1:0]   vec_pend_q;
    logic                spurious_q;
    logic                bus_fault_q;

    logic [N_SRCS-1:0]   rd_pend;
    logic [ID_W-1:0]     rd_id;
    logic                rd_any;
    logic                bus_abort;
    logic                unused_rd;

    assign rd_pend   = m_dat_r[N_SRCS-1:0];
    assign unused_rd = ^m_dat_r;

    fw_local_intc_prio_enc #(
        .N_SRCS (N_SRCS),
        .ID_W   (ID_W)
    ) u_prio_enc (
        .req_i (rd_pend),
        .id_o  (rd_id),
        .any_o (rd_any)
    );

    // An error wins over a simultaneous ack; the timeout fires on the TIMEOUT-th cycle of cyc.
    assign bus_abort = m_err || (!m_ack && (tmo_q == TMO_LAST));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            hold_q      <= '0;
            m_adr_q     <= '0;
            m_dat_w_q   <= '0;
            m_cyc_q     <= 1'b0;
            m_stb_q     <= 1'b0;
            m_we_q      <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
            vec_pend_q  <= '0;
            spurious_q  <= 1'b0;
            bus_fault_q <= 1'b0;
        end else begin
            spurious_q  <= 1'b0;
            bus_fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (irq) begin
                        state_q <= ST_RD;
                        m_cyc_q <= 1'b1;
                        m_stb_q <= 1'b1;
                        m_we_q  <= 1'b0;
                        m_adr_q <= PEND_ADDR;
                        tmo_q   <= '0;
                    end
                end
                ST_RD: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (bus_abort) begin
                        m_cyc_q     <= 1'b0;
                        m_stb_q     <= 1'b0;
                        m_we_q      <= 1'b0;
                        bus_fault_q <= 1'b1;
                        hold_q      <= '0;
                        state_q     <= ST_HOLD;
                    end else if (m_ack) begin
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        if (rd_any) begin
                            vec_pend_q  <= rd_pend;
                            vec_id_q    <= rd_id;
                            vec_valid_q <= 1'b1;
                            state_q     <= ST_PRESENT;
                        end else begin
                            spurious_q <= 1'b1;
                            hold_q     <= '0;
                            state_q    <= ST_HOLD;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (vec_ready) begin
                        vec_valid_q <= 1'b0;
                        m_cyc_q     <= 1'b1;
                        m_stb_q     <= 1'b1;
                        m_we_q      <= 1'b1;
                        m_adr_q     <= ACK_ADDR;
                        m_dat_w_q   <= 32'(1) << vec_id_q;
                        tmo_q       <= '0;
                        state_q     <= ST_WR;
                    end
                end
                ST_WR: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (bus_abort || m_ack) begin
                        m_cyc_q     <= 1'b0;
                        m_stb_q     <= 1'b0;
                        m_we_q      <= 1'b0;
                        bus_fault_q <= bus_abort;
                        hold_q      <= '0;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_adr     = m_adr_q;
    assign m_dat_w   = m_dat_w_q;
    assign m_cyc     = m_cyc_q;
    assign m_stb     = m_stb_q;
    assign m_we      = m_we_q;
    assign m_sel     = 4'hF;
    assign vec_valid = vec_valid_q;
    assign vec_id    = vec_id_q;
    assign vec_pend  = vec_pend_q;
    assign spurious  = spurious_q;
    assign bus_fault = bus_fault_q;

endmodule

// File: tb/tb_fw_local_intc_wb_dispatch.sv
// tb/tb_fw_local_intc_wb_dispatch.sv - randomized self-checking bench for the interrupt dispatch initiator
module tb_fw_local_intc_wb_dispatch;

    localparam int          N  = 4;
    localparam int          TMO = 16;
    localparam logic [31:0] PA = 32'h0;
    localparam logic [31:0] AA = 32'h4;

    logic        clock = 1'b0;
    logic        reset;
    logic        irq;
    logic [31:0] m_adr, m_dat_w, m_dat_r;
    logic        m_cyc, m_stb, m_we, m_ack, m_err;
    logic [3:0]  m_sel;
    logic        vec_valid, vec_ready, spurious, bus_fault;
    logic [1:0]  vec_id;
    logic [3:0]  vec_pend;

    always #5 clock = ~clock;

    fw_local_intc_wb_dispatch #(
        .N_SRCS(N), .ADR_W(32), .PEND_ADDR(PA), .ACK_ADDR(AA), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .irq(irq),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_ack(m_ack), .m_err(m_err),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_id(vec_id), .vec_pend(vec_pend),
        .spurious(spurious), .bus_fault(bus_fault)
    );

    typedef struct { bit we; logic [31:0] adr; logic [31:0] dat; } tx_t;
    typedef struct { int id; logic [3:0] pend; } vec_t;

    tx_t  tx_log[$];
    vec_t vec_log[$];
    int   n_tests = 0, n_fail = 0;
    int   spur_cnt = 0, fault_cnt = 0, cyc_cycles = 0, stb_viol = 0, both_viol = 0;
    int   tgt_mode = 0;
    int   rdy_mode = 0;
    int   load_gen = 0;
    logic [3:0] pend_m = 4'h0;
    logic [3:0] load_val = 4'h0;
    bit   irq_force = 1'b0;

    assign irq = irq_force | (pend_m != 4'h0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Controller model: pending register with W1C ack, one wait state; modes 1 silent, 2 err on read, 3 ack+err on read.
    initial begin
        int          seen_gen;
        int          wcnt;
        logic [31:0] r;
        seen_gen = 0; wcnt = 0;
        m_ack = 1'b0; m_err = 1'b0; m_dat_r = 32'h0;
        forever begin
            @(posedge clock); #1;
            if (load_gen != seen_gen) begin
                seen_gen = load_gen;
                pend_m   = load_val;
            end
            if (m_ack || m_err) begin
                m_ack = 1'b0; m_err = 1'b0; wcnt = 0;
            end else if (m_cyc && m_stb) begin
                if (wcnt == 0) begin
                    wcnt = 1;
                end else if (tgt_mode != 1) begin
                    if (!m_we) begin
                        r = $urandom;
                        r[3:0] = pend_m;
                        m_dat_r = r;
                        if (tgt_mode == 2) m_err = 1'b1;
                        else if (tgt_mode == 3) begin m_err = 1'b1; m_ack = 1'b1; end
                        else m_ack = 1'b1;
                    end else begin
                        m_ack = 1'b1;
                        if (m_adr == AA) pend_m = pend_m & ~m_dat_w[3:0];
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        vec_ready = 1'b0;
        forever begin
            @(posedge clock); #2;
            case (rdy_mode)
                0:       vec_ready = 1'b1;
                1:       vec_ready = 1'($urandom % 2);
                default: vec_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (m_cyc && m_stb && m_ack && !m_err)
                tx_log.push_back('{m_we, m_adr, m_we ? m_dat_w : m_dat_r});
            if (vec_valid && vec_ready) vec_log.push_back('{int'(vec_id), vec_pend});
            if (spurious) spur_cnt++;
            if (bus_fault) fault_cnt++;
            if (m_cyc) cyc_cycles++;
            if (m_stb && !m_cyc) stb_viol++;
            if (vec_valid && m_cyc) both_viol++;
        end
    end

    task automatic wait_quiet(input string tag);
        int i;
        i = 0;
        while (i < 400 && (irq || m_cyc || vec_valid)) begin
            @(negedge clock);
            i++;
        end
        check({tag, "_quiet"}, 32'(i < 400), 32'd1);
        repeat (6) @(negedge clock);
    endtask

    // Reference: each pass reads the pending word, dispatches its lowest bit and acknowledges it.
    task automatic run_scenario(input logic [3:0] p);
        int         t0, v0, id;
        tx_t        et[$];
        vec_t       ev[$];
        logic [3:0] q;
        t0 = tx_log.size();
        v0 = vec_log.size();
        q  = p;
        while (q != 4'h0) begin
            id = 0;
            while (!q[id]) id++;
            et.push_back('{1'b0, PA, 32'h0});
            ev.push_back('{id, q});
            et.push_back('{1'b1, AA, 32'(1) << id});
            q[id] = 1'b0;
        end
        load_val = p;
        load_gen++;
        repeat (2) @(negedge clock);
        wait_quiet("scn");
        check("scn_ntx", 32'(tx_log.size() - t0), 32'(et.size()));
        check("scn_nvec", 32'(vec_log.size() - v0), 32'(ev.size()));
        if (tx_log.size() - t0 == et.size()) begin
            for (int k = 0; k < et.size(); k++) begin
                check("tx_we", 32'(tx_log[t0+k].we), 32'(et[k].we));
                check("tx_adr", tx_log[t0+k].adr, et[k].adr);
                if (et[k].we) check("tx_dat", tx_log[t0+k].dat, et[k].dat);
            end
        end
        if (vec_log.size() - v0 == ev.size()) begin
            for (int k = 0; k < ev.size(); k++) begin
                check("vec_id", 32'(vec_log[v0+k].id), 32'(ev[k].id));
                check("vec_pend", 32'(vec_log[v0+k].pend), 32'(ev[k].pend));
            end
        end
    endtask

    // Drives irq with an empty pending word in the given target mode and checks fault/spurious deltas.
    task automatic forced_pass(input string tag, input int mode, input int exp_spur,
                               input int exp_fault, input int exp_tx, input int exp_cyc);
        int s0, f0, v0, t0, c0, i;
        s0 = spur_cnt; f0 = fault_cnt; v0 = vec_log.size(); t0 = tx_log.size(); c0 = cyc_cycles;
        tgt_mode  = mode;
        irq_force = 1'b1;
        i = 0;
        while (i < 100 && spur_cnt == s0 && fault_cnt == f0) begin
            @(negedge clock);
            i++;
        end
        irq_force = 1'b0;
        check({tag, "_done"}, 32'(i < 100), 32'd1);
        repeat (10) @(negedge clock);
        tgt_mode = 0;
        check({tag, "_spur"}, 32'(spur_cnt - s0), 32'(exp_spur));
        check({tag, "_fault"}, 32'(fault_cnt - f0), 32'(exp_fault));
        check({tag, "_nvec"}, 32'(vec_log.size() - v0), 32'd0);
        check({tag, "_ntx"}, 32'(tx_log.size() - t0), 32'(exp_tx));
        if (exp_cyc > 0) check({tag, "_cyc"}, 32'(cyc_cycles - c0), 32'(exp_cyc));
    endtask

    initial begin
        int bad, i;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_cyc", 32'(m_cyc), 32'd0);
        check("rst_stb", 32'(m_stb), 32'd0);
        check("rst_we", 32'(m_we), 32'd0);
        check("rst_adr", m_adr, 32'd0);
        check("rst_dat_w", m_dat_w, 32'd0);
        check("rst_vvalid", 32'(vec_valid), 32'd0);
        check("rst_vid", 32'(vec_id), 32'd0);
        check("rst_vpend", 32'(vec_pend), 32'd0);
        check("rst_spur", 32'(spurious), 32'd0);
        check("rst_fault", 32'(bus_fault), 32'd0);
        check("rst_sel", 32'(m_sel), 32'hF);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        run_scenario(4'b0100);
        run_scenario(4'b1010);
        rdy_mode = 1;
        repeat (20) run_scenario(4'($urandom));
        rdy_mode = 0;
        run_scenario(4'b1111);

        // Backpressure: vector must hold and the bus must stay idle until ready.
        rdy_mode = 2;
        load_val = 4'b0110;
        load_gen++;
        i = 0;
        while (i < 50 && !vec_valid) begin @(negedge clock); i++; end
        check("bp_valid", 32'(vec_valid), 32'd1);
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (!vec_valid || vec_id != 2'd1 || vec_pend != 4'b0110 || m_cyc) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        rdy_mode = 0;
        i = 0;
        while (i < 5 && !vec_ready) begin @(negedge clock); i++; end
        check("bp_held_valid", 32'(vec_valid), 32'd1);
        @(posedge clock); #1;
        check("bp_wr_cyc", 32'(m_cyc), 32'd1);
        check("bp_wr_we", 32'(m_we), 32'd1);
        check("bp_wr_adr", m_adr, AA);
        check("bp_wr_dat", m_dat_w, 32'h2);
        check("bp_vvalid_low", 32'(vec_valid), 32'd0);
        wait_quiet("bp");
        check("bp_last_id", 32'(vec_log[vec_log.size()-1].id), 32'd2);

        forced_pass("spur", 0, 1, 0, 1, 0);
        forced_pass("tmo", 1, 0, 1, 0, TMO);
        forced_pass("err_rd", 2, 0, 1, 0, 0);
        forced_pass("ack_err", 3, 0, 1, 0, 0);

        // Asynchronous reset while a read is outstanding.
        tgt_mode  = 1;
        irq_force = 1'b1;
        i = 0;
        while (i < 20 && !m_cyc) begin @(negedge clock); i++; end
        check("mid_cyc_up", 32'(m_cyc), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_cyc", 32'(m_cyc), 32'd0);
        check("mid_rst_stb", 32'(m_stb), 32'd0);
        irq_force = 1'b0;
        tgt_mode  = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("mid_idle_cyc", 32'(m_cyc), 32'd0);
        run_scenario(4'b0001);

        check("stb_without_cyc", 32'(stb_viol), 32'd0);
        check("valid_with_cyc", 32'(both_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
